// File: rtl/coef_pkg.sv
// Shared types and reset contents for the double-buffered coefficient store.
package coef_pkg;

    // Loader progress: waiting for a first word, or partway through a set.
    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } ld_state_t;

    localparam int DEFAULT_NTAPS = 32;

    // Antisymmetric high-pass set: tap[31-k] == -tap[k].
    localparam logic [15:0] DEFAULT_TAPS [DEFAULT_NTAPS] = '{
        16'hFFDF, 16'hFFD0, 16'hFFB9, 16'hFF91, 16'hFF4E, 16'hFEF0, 16'hFE6A, 16'hFDB5,
        16'hFCC8, 16'hFBA0, 16'hFA3B, 16'hF8A3, 16'hF6E9, 16'hF521, 16'hF36B, 16'h5099,
        16'hAF67, 16'h0C95, 16'h0ADF, 16'h0917, 16'h075D, 16'h05C5, 16'h0460, 16'h0338,
        16'h024B, 16'h0196, 16'h0110, 16'h00B2, 16'h006F, 16'h0047, 16'h0030, 16'h0021
    };

    // Reset value for tap idx; banks deeper than the default set are zero-filled.
    function automatic logic [15:0] default_tap(input int idx);
        if (idx < DEFAULT_NTAPS) begin
            return DEFAULT_TAPS[idx[4:0]];
        end
        return 16'h0000;
    endfunction

endpackage

// File: rtl/coef_loader_fsm.sv
// Loader control: word counter, framing check, shadow write strobe and the
// bank-ownership flags (active bank, shadow ready, busy, error).
module coef_loader_fsm
    import coef_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              ld_last,
    input  logic              swap_req,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              active_bank,
    output logic              shadow_ready,
    output logic              load_busy,
    output logic              load_err,
    output ld_state_t         state
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] count;
    logic              swap_do;
    logic              at_last;

    // A swap is only honoured when a complete, clean set is waiting.
    assign swap_do = swap_req & shadow_ready;
    assign at_last = (count == LAST_IDX);

    // The write goes to whichever bank is shadow after this edge, so a first
    // word arriving alongside a swap lands in the bank being retired.
    assign wr_en   = accept;
    assign wr_addr = count;
    assign wr_bank = swap_do ? active_bank : ~active_bank;

    // Loader state, word counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            active_bank  <= 1'b0;
            shadow_ready <= 1'b0;
            load_busy    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            if (swap_do) begin
                active_bank  <= ~active_bank;
                shadow_ready <= 1'b0;
            end
            if (accept) begin
                if (state == IDLE) begin
                    shadow_ready <= 1'b0;
                    load_err     <= 1'b0;
                    load_busy    <= 1'b1;
                end
                if (ld_last || at_last) begin
                    state     <= IDLE;
                    count     <= '0;
                    load_busy <= 1'b0;
                    if (ld_last && at_last) begin
                        shadow_ready <= 1'b1;
                    end else begin
                        load_err <= 1'b1;
                    end
                end else begin
                    state <= LOAD;
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/coef_bank_mem.sv
// Double-buffered FIR coefficient store. The filter reads the active bank
// with a registered one-cycle read; the host streams a new set into the
// shadow bank and promotes it with swap_req.
// Handshake: a load word transfers on a rising edge where ld_valid and
// ld_ready are both high; ld_ready is high in every loader state.
module coef_bank_mem
    import coef_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WIDTH-1:0]  ld_data,
    input  logic              ld_last,
    input  logic              swap_req,
    output logic              active_bank,
    output logic              shadow_ready,
    output logic              load_busy,
    output logic              load_err
);

    logic [WIDTH-1:0]  bank0 [DEPTH];
    logic [WIDTH-1:0]  bank1 [DEPTH];
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    ld_state_t         loader_state;

    assign ld_ready = (loader_state == IDLE) || (loader_state == LOAD);

    coef_loader_fsm #(.DEPTH(DEPTH)) u_loader (
        .clk          (clk),
        .rst          (rst),
        .accept       (ld_valid & ld_ready),
        .ld_last      (ld_last),
        .swap_req     (swap_req),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_addr      (wr_addr),
        .active_bank  (active_bank),
        .shadow_ready (shadow_ready),
        .load_busy    (load_busy),
        .load_err     (load_err),
        .state        (loader_state)
    );

    // Coefficient storage: both banks come out of reset holding the default set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank0[i] <= WIDTH'($signed(default_tap(i)));
                bank1[i] <= WIDTH'($signed(default_tap(i)));
            end
        end else if (wr_en) begin
            if (wr_bank) begin
                bank1[wr_addr] <= ld_data;
            end else begin
                bank0[wr_addr] <= ld_data;
            end
        end
    end

    // Registered tap read from the bank that is active at the request edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= active_bank ? bank1[rd_addr] : bank0[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_coef_bank_mem.sv
// Bench for coef_bank_mem: table of post-reset reads, hand sequences for the
// load/swap corner cases, then random operations against a set-level model.
module tb_coef_bank_mem;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              ld_valid;
    logic              ld_ready;
    logic [WIDTH-1:0]  ld_data;
    logic              ld_last;
    logic              swap_req;
    logic              active_bank;
    logic              shadow_ready;
    logic              load_busy;
    logic              load_err;

    coef_bank_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .swap_req     (swap_req),
        .active_bank  (active_bank),
        .shadow_ready (shadow_ready),
        .load_busy    (load_busy),
        .load_err     (load_err)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: whole banks plus ownership flags.
    logic [WIDTH-1:0] dflt [DEPTH];
    logic [WIDTH-1:0] m_bank [2][DEPTH];
    logic             m_active;
    logic             m_sready;
    logic             m_err;
    logic [WIDTH-1:0] m_rd_data;
    logic [WIDTH-1:0] ld_words [DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  exp;
    } rd_vec_t;

    rd_vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_bank[0][i] = dflt[i];
            m_bank[1][i] = dflt[i];
        end
        m_active  = 1'b0;
        m_sready  = 1'b0;
        m_err     = 1'b0;
        m_rd_data = '0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s.rd_data", tag), 32'(rd_data), 32'h0);
        check($sformatf("%s.rd_valid", tag), 32'(rd_valid), 32'h0);
        check($sformatf("%s.active", tag), 32'(active_bank), 32'h0);
        check($sformatf("%s.sready", tag), 32'(shadow_ready), 32'h0);
        check($sformatf("%s.busy", tag), 32'(load_busy), 32'h0);
        check($sformatf("%s.err", tag), 32'(load_err), 32'h0);
        check($sformatf("%s.ld_ready", tag), 32'(ld_ready), 32'h1);
    endtask

    task automatic check_status(input string tag);
        check($sformatf("%s.active", tag), 32'(active_bank), 32'(m_active));
        check($sformatf("%s.sready", tag), 32'(shadow_ready), 32'(m_sready));
        check($sformatf("%s.err", tag), 32'(load_err), 32'(m_err));
        check($sformatf("%s.busy", tag), 32'(load_busy), 32'h0);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp,
                           input string name);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        check($sformatf("%s.valid", name), 32'(rd_valid), 32'h1);
        check($sformatf("%s.data", name), 32'(rd_data), 32'(exp));
        m_rd_data = exp;
    endtask

    // Stream n_words from ld_words; ld_last on word last_at (-1 = never).
    task automatic load_set(input int n_words, input int last_at, input bit with_swap,
                            input string tag);
        for (int k = 0; k < n_words; k++) begin
            ld_valid = 1'b1;
            ld_data  = ld_words[k];
            ld_last  = (k == last_at);
            swap_req = with_swap && (k == 0);
            check($sformatf("%s.ld_ready%0d", tag, k), 32'(ld_ready), 32'h1);
            tick();
            swap_req = 1'b0;
            check($sformatf("%s.busy%0d", tag, k), 32'(load_busy), 32'(k < n_words - 1));
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (with_swap && m_sready) begin
            m_active = ~m_active;
            m_sready = 1'b0;
        end
        if (n_words == DEPTH && last_at == DEPTH - 1) begin
            for (int i = 0; i < DEPTH; i++) m_bank[m_active ? 0 : 1][i] = ld_words[i];
            m_sready = 1'b1;
            m_err    = 1'b0;
        end else begin
            m_sready = 1'b0;
            m_err    = 1'b1;
        end
        check_status(tag);
    endtask

    task automatic swap_pulse(input string tag);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        if (m_sready) begin
            m_active = ~m_active;
            m_sready = 1'b0;
        end
        check_status(tag);
    endtask

    task automatic read_burst(input int n);
        logic             en;
        logic [WIDTH-1:0] exp;
        for (int c = 0; c < n; c++) begin
            en      = 1'($urandom_range(0, 1));
            rd_en   = en;
            rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            if (en) exp_q.push_back(m_bank[m_active][rd_addr]);
            tick();
            check("rnd_rd.valid", 32'(rd_valid), 32'(en));
            if (en) begin
                exp = exp_q.pop_front();
                check("rnd_rd.data", 32'(rd_data), 32'(exp));
                m_rd_data = exp;
            end else begin
                check("rnd_rd.hold", 32'(rd_data), 32'(m_rd_data));
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) ld_words[i] = WIDTH'($urandom);
    endtask

    task automatic fill_ramp(input logic [WIDTH-1:0] base);
        for (int i = 0; i < DEPTH; i++) ld_words[i] = base + WIDTH'(i);
    endtask

    initial begin
        dflt = '{
            16'hFFDF, 16'hFFD0, 16'hFFB9, 16'hFF91, 16'hFF4E, 16'hFEF0, 16'hFE6A, 16'hFDB5,
            16'hFCC8, 16'hFBA0, 16'hFA3B, 16'hF8A3, 16'hF6E9, 16'hF521, 16'hF36B, 16'h5099,
            16'hAF67, 16'h0C95, 16'h0ADF, 16'h0917, 16'h075D, 16'h05C5, 16'h0460, 16'h0338,
            16'h024B, 16'h0196, 16'h0110, 16'h00B2, 16'h006F, 16'h0047, 16'h0030, 16'h0021
        };
        vecs[0] = '{addr: 5'd0,  exp: 16'hFFDF};
        vecs[1] = '{addr: 5'd15, exp: 16'h5099};
        vecs[2] = '{addr: 5'd16, exp: 16'hAF67};
        vecs[3] = '{addr: 5'd31, exp: 16'h0021};
        vecs[4] = '{addr: 5'd5,  exp: 16'hFEF0};
        vecs[5] = '{addr: 5'd26, exp: 16'h0110};

        // Reset.
        rst      = 1'b1;
        rd_en    = 1'b0;
        rd_addr  = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        swap_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Default taps out of reset.
        foreach (vecs[i]) do_read(vecs[i].addr, vecs[i].exp, $sformatf("tbl_rd%0d", vecs[i].addr));
        tick();
        check("hold.valid", 32'(rd_valid), 32'h0);
        check("hold.data", 32'(rd_data), 32'h0110);

        // Clean load; active bank still serves defaults until the swap.
        fill_ramp(16'h0100);
        load_set(32, 31, 1'b0, "load1");
        do_read(5'd5, 16'hFEF0, "pre_swap_rd5");

        // Read issued in the swap cycle sees the old bank.
        rd_en    = 1'b1;
        rd_addr  = 5'd5;
        swap_req = 1'b1;
        tick();
        rd_en    = 1'b0;
        swap_req = 1'b0;
        m_active = 1'b1;
        m_sready = 1'b0;
        m_rd_data = 16'hFEF0;
        check("swap_cycle_rd.data", 32'(rd_data), 32'hFEF0);
        check("swap.active", 32'(active_bank), 32'h1);
        check("swap.sready", 32'(shadow_ready), 32'h0);
        do_read(5'd5, 16'h0105, "post_swap_rd5");

        // Early ld_last: error, and a later swap request is ignored.
        fill_random();
        load_set(11, 10, 1'b0, "early_last");
        swap_pulse("swap_after_err");
        check("swap_after_err.active1", 32'(active_bank), 32'h1);

        // Missing ld_last, then a clean load clears the error.
        fill_random();
        load_set(32, -1, 1'b0, "no_last");
        fill_ramp(16'h2000);
        load_set(32, 31, 1'b0, "reload");

        // Swap coinciding with the first word of the next load.
        fill_ramp(16'h3000);
        load_set(32, 31, 1'b1, "b2b");
        check("b2b.active0", 32'(active_bank), 32'h0);
        do_read(5'd7, 16'h2007, "b2b_rd7_a");
        swap_pulse("b2b_swap2");
        check("b2b_swap2.active1", 32'(active_bank), 32'h1);
        do_read(5'd7, 16'h3007, "b2b_rd7_b");

        // Swap mid-load is ignored; reset mid-load discards everything.
        fill_random();
        for (int k = 0; k <= 20; k++) begin
            ld_valid = 1'b1;
            ld_data  = ld_words[k];
            ld_last  = 1'b0;
            swap_req = (k == 12);
            if (k < 20) begin
                tick();
                swap_req = 1'b0;
                check($sformatf("midload.busy%0d", k), 32'(load_busy), 32'h1);
                check($sformatf("midload.active%0d", k), 32'(active_bank), 32'(m_active));
            end
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midload_rst");
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        check_reset_outputs("post_rst");
        do_read(5'd0, 16'hFFDF, "post_rst_rd0");
        do_read(5'd31, 16'h0021, "post_rst_rd31");

        // Random operations against the model.
        for (int op_i = 0; op_i < 40; op_i++) begin
            case ($urandom_range(0, 3))
                0: read_burst(8);
                1: begin
                    fill_random();
                    load_set(32, 31, 1'($urandom_range(0, 1)), "rnd_good");
                end
                2: begin
                    int k;
                    fill_random();
                    if ($urandom_range(0, 1) == 1) begin
                        load_set(32, -1, 1'($urandom_range(0, 1)), "rnd_nolast");
                    end else begin
                        k = $urandom_range(0, 30);
                        load_set(k + 1, k, 1'($urandom_range(0, 1)), "rnd_early");
                    end
                end
                default: swap_pulse("rnd_swap");
            endcase
        end
        read_burst(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
